// File: rtl/xoodyak_result_collector.sv
// -----------------------------------------------------------------------------
// xoodyak_result_collector
//
// Receive-side companion to the xoodyak_build core. It watches the core's
// start/opmode/finished protocol, captures the crypt/decrypt text and the
// squeeze tag, checks the tag on decrypt, and holds exactly one result for the
// host behind a valid/ready handshake. All core outputs reach the host only
// through this block.
//
// Optional feature macro: XOOD_MASK_PT_EN
//   defined   : a decrypt result whose tag check failed presents all-zero
//               res_text, so unverified plaintext never leaves the block.
//   undefined : res_text always carries the captured text; the host must gate
//               on res_auth_ok.
//
// Parameters
//   TEXT_W  width of core textout / result text
//   TAG_W   width of the authentication tag (core_textout[TAG_W-1:0])
//
// Ports
//   eph1           in   clock
//   reset          in   asynchronous active-high reset
//   core_start     in   1-cycle pulse, core operation issued
//   core_opmode    in   [3]=continue, [2:0] operation code
//   core_finished  in   1-cycle pulse, core operation complete
//   core_textout   in   core output text (valid with core_finished)
//   exp_tag        in   expected tag for decrypt, sampled on squeeze finished
//   res_valid      out  result held
//   res_ready      in   host accepts result when res_valid & res_ready
//   res_text       out  captured crypt/decrypt text
//   res_tag        out  captured squeeze tag
//   res_dec        out  1 = result came from a decrypt
//   res_auth_ok    out  decrypt: tag == exp_tag; otherwise 1
//   busy           out  state != IDLE or result held
//   err_proto      out  sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module xoodyak_result_collector #(
  parameter int TEXT_W = 192,
  parameter int TAG_W  = 128
) (
  input  logic              eph1,
  input  logic              reset,
  input  logic              core_start,
  input  logic [3:0]        core_opmode,
  input  logic              core_finished,
  input  logic [TEXT_W-1:0] core_textout,
  input  logic [TAG_W-1:0]  exp_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TEXT_W-1:0] res_text,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_dec,
  output logic              res_auth_ok,
  output logic              busy,
  output logic              err_proto
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OP   = 2'd1,
    ST_HAVE_TEXT = 2'd2,
    ST_OUT       = 2'd3
  } state_t;

  localparam logic [2:0] OP_IDLE    = 3'd0;
  localparam logic [2:0] OP_CRYPT   = 3'd4;
  localparam logic [2:0] OP_DECRYPT = 3'd5;
  localparam logic [2:0] OP_SQUEEZE = 3'd6;

  // Exact full-width tag equality; no partial or arithmetic compare.
  function automatic logic tag_match(input logic [TAG_W-1:0] a,
                                     input logic [TAG_W-1:0] b);
    return (a == b);
  endfunction

  // Plaintext presented to the host for a given auth outcome.
  function automatic logic [TEXT_W-1:0] present_text(input logic [TEXT_W-1:0] text,
                                                     input logic              dec,
                                                     input logic              auth_ok);
`ifdef XOOD_MASK_PT_EN
    if (dec && !auth_ok) begin
      return {TEXT_W{1'b0}};
    end else begin
      return text;
    end
`else
    return text;
`endif
  endfunction

  // State and datapath registers
  state_t              r_state;
  logic [2:0]          r_op;
  logic [TEXT_W-1:0]   r_text;
  logic                r_dec;
  logic                r_have_text;
  logic [TAG_W-1:0]    r_tag;
  logic                r_auth_ok;
  logic                r_valid;
  logic [TEXT_W-1:0]   r_res_text;
  logic                r_res_dec;
  logic                r_busy;
  logic                r_err;

  // Next-state values
  state_t              w_state_nxt;
  logic [2:0]          w_op_nxt;
  logic [TEXT_W-1:0]   w_text_nxt;
  logic                w_dec_nxt;
  logic                w_have_text_nxt;
  logic [TAG_W-1:0]    w_tag_nxt;
  logic                w_auth_ok_nxt;
  logic                w_valid_nxt;
  logic [TEXT_W-1:0]   w_res_text_nxt;
  logic                w_res_dec_nxt;
  logic                w_err_nxt;

  logic                w_start_op;
  logic                w_handshake;
  logic                w_sq_auth;
  logic [TEXT_W-1:0]   w_sq_text;

  assign w_start_op  = core_start & (core_opmode[2:0] != OP_IDLE);
  assign w_handshake = r_valid & res_ready;

  // A squeeze with no text held produces a tag-only result: dec is 0 and the
  // text is zero, so auth_ok collapses to 1.
  assign w_sq_auth = r_dec ? tag_match(core_textout[TAG_W-1:0], exp_tag) : 1'b1;
  assign w_sq_text = r_have_text ? present_text(r_text, r_dec, w_sq_auth)
                                 : {TEXT_W{1'b0}};

  // Next-state and datapath update for the collector FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_text_nxt      = r_text;
    w_dec_nxt       = r_dec;
    w_have_text_nxt = r_have_text;
    w_tag_nxt       = r_tag;
    w_auth_ok_nxt   = r_auth_ok;
    w_valid_nxt     = r_valid;
    w_res_text_nxt  = r_res_text;
    w_res_dec_nxt   = r_res_dec;
    w_err_nxt       = r_err;

    case (r_state)
      ST_IDLE, ST_HAVE_TEXT: begin
        if (core_finished) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
        // opmode 0 is a no-op and leaves the state untouched.
        if (w_start_op) begin
          w_op_nxt    = core_opmode[2:0];
          w_state_nxt = ST_WAIT_OP;
        end else begin
          w_state_nxt = r_state;
        end
      end

      ST_WAIT_OP: begin
        if (core_finished) begin
          case (r_op)
            OP_CRYPT, OP_DECRYPT: begin
              // A second text before squeeze clobbers the first; flag it.
              if (r_have_text) begin
                w_err_nxt = 1'b1;
              end else begin
                w_err_nxt = r_err;
              end
              w_text_nxt      = core_textout;
              w_dec_nxt       = (r_op == OP_DECRYPT);
              w_have_text_nxt = 1'b1;
              w_state_nxt     = ST_HAVE_TEXT;
            end
            OP_SQUEEZE: begin
              w_tag_nxt      = core_textout[TAG_W-1:0];
              w_auth_ok_nxt  = w_sq_auth;
              w_res_text_nxt = w_sq_text;
              w_res_dec_nxt  = r_dec & r_have_text;
              w_valid_nxt    = 1'b1;
              w_state_nxt    = ST_OUT;
            end
            default: begin
              w_state_nxt = r_have_text ? ST_HAVE_TEXT : ST_IDLE;
            end
          endcase
          // Finished is retired first; a same-cycle start then sees the
          // resulting state. A start landing on a fresh result is refused.
          if (core_start) begin
            if (w_state_nxt == ST_OUT) begin
              w_err_nxt = 1'b1;
            end else if (w_start_op) begin
              w_op_nxt    = core_opmode[2:0];
              w_state_nxt = ST_WAIT_OP;
            end else begin
              w_op_nxt = r_op;
            end
          end else begin
            w_op_nxt = r_op;
          end
        end else if (core_start) begin
          w_err_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT_OP;
        end
      end

      ST_OUT: begin
        if (core_finished) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
        if (w_handshake) begin
          w_valid_nxt     = 1'b0;
          w_text_nxt      = {TEXT_W{1'b0}};
          w_dec_nxt       = 1'b0;
          w_have_text_nxt = 1'b0;
          w_tag_nxt       = {TAG_W{1'b0}};
          w_auth_ok_nxt   = 1'b0;
          w_res_text_nxt  = {TEXT_W{1'b0}};
          w_res_dec_nxt   = 1'b0;
          if (w_start_op) begin
            w_op_nxt    = core_opmode[2:0];
            w_state_nxt = ST_WAIT_OP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (core_start) begin
          // The held result is never overwritten.
          w_err_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Collector FSM register bank with registered host-facing outputs.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'd0;
      r_text      <= {TEXT_W{1'b0}};
      r_dec       <= 1'b0;
      r_have_text <= 1'b0;
      r_tag       <= {TAG_W{1'b0}};
      r_auth_ok   <= 1'b0;
      r_valid     <= 1'b0;
      r_res_text  <= {TEXT_W{1'b0}};
      r_res_dec   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_text      <= w_text_nxt;
      r_dec       <= w_dec_nxt;
      r_have_text <= w_have_text_nxt;
      r_tag       <= w_tag_nxt;
      r_auth_ok   <= w_auth_ok_nxt;
      r_valid     <= w_valid_nxt;
      r_res_text  <= w_res_text_nxt;
      r_res_dec   <= w_res_dec_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE) | w_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign res_valid   = r_valid;
  assign res_text    = r_res_text;
  assign res_tag     = r_tag;
  assign res_dec     = r_res_dec;
  assign res_auth_ok = r_auth_ok;
  assign busy        = r_busy;
  assign err_proto   = r_err;

endmodule

// File: tb/tb_xoodyak_result_collector.sv
module tb_xoodyak_result_collector;

  localparam int TEXT_W = 192;
  localparam int TAG_W  = 128;

  logic              eph1;
  logic              reset;
  logic              core_start;
  logic [3:0]        core_opmode;
  logic              core_finished;
  logic [TEXT_W-1:0] core_textout;
  logic [TAG_W-1:0]  exp_tag;
  logic              res_valid;
  logic              res_ready;
  logic [TEXT_W-1:0] res_text;
  logic [TAG_W-1:0]  res_tag;
  logic              res_dec;
  logic              res_auth_ok;
  logic              busy;
  logic              err_proto;

  int checks = 0;
  int errors = 0;

  localparam logic [TEXT_W-1:0] T_ENC  = 192'h4d4e4f50_51525354_55565758_595a5b5c_45464748_494a4b4c;
  localparam logic [TEXT_W-1:0] T_DEC  = 192'h01020304_05060708_090a0b0c_0d0e0f10_11121314_15161718;
  localparam logic [TEXT_W-1:0] T_DEC2 = 192'hdeadbeef_cafef00d_12345678_9abcdef0_0badc0de_feedface;
  localparam logic [TAG_W-1:0]  TAG_A5 = {16{8'hA5}};
  localparam logic [TAG_W-1:0]  EXP_T  = 128'h38393a3b_3c3d3e3f_30313233_34353637;

  xoodyak_result_collector #(.TEXT_W(TEXT_W), .TAG_W(TAG_W)) dut (
    .eph1          (eph1),
    .reset         (reset),
    .core_start    (core_start),
    .core_opmode   (core_opmode),
    .core_finished (core_finished),
    .core_textout  (core_textout),
    .exp_tag       (exp_tag),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_text      (res_text),
    .res_tag       (res_tag),
    .res_dec       (res_dec),
    .res_auth_ok   (res_auth_ok),
    .busy          (busy),
    .err_proto     (err_proto)
  );

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  // All stimulus tasks start and end on a falling edge.
  task automatic do_start(input logic [3:0] op);
    core_start  = 1'b1;
    core_opmode = op;
    @(negedge eph1);
    core_start  = 1'b0;
    core_opmode = 4'd0;
  endtask

  task automatic do_finish(input logic [TEXT_W-1:0] t);
    core_finished = 1'b1;
    core_textout  = t;
    @(negedge eph1);
    core_finished = 1'b0;
    core_textout  = {TEXT_W{1'b0}};
  endtask

  task automatic do_handshake();
    res_ready = 1'b1;
    @(negedge eph1);
    res_ready = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge eph1);
    @(negedge eph1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({res_valid, res_dec, res_auth_ok, busy, err_proto} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {res_valid, res_dec, res_auth_ok, busy, err_proto});
    end
    checks++;
    if (res_text !== {TEXT_W{1'b0}} || res_tag !== {TAG_W{1'b0}}) begin
      errors++;
      $display("FAIL reset_data got text=%h tag=%h want 0", res_text, res_tag);
    end
  endtask

  task automatic test_encrypt();
    do_start(4'd1); do_finish(192'h1);
    do_start(4'd2); do_finish(192'h2);
    do_start(4'd3); do_finish(192'h3);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL enc_after_setup got busy=%b valid=%b want 0 0", busy, res_valid);
    end
    do_start(4'd4); do_finish(T_ENC);
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL enc_have_text got busy=%b valid=%b want 1 0", busy, res_valid);
    end
    do_start(4'd6); do_finish({64'hffff_ffff_ffff_ffff, TAG_A5});
    checks++;
    if (res_valid !== 1'b1 || res_text !== T_ENC || res_tag !== TAG_A5) begin
      errors++;
      $display("FAIL enc_result got valid=%b text=%h tag=%h want 1 %h %h", res_valid, res_text, res_tag, T_ENC, TAG_A5);
    end
    checks++;
    if (res_dec !== 1'b0 || res_auth_ok !== 1'b1 || busy !== 1'b1 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL enc_flags got dec=%b auth=%b busy=%b err=%b want 0 1 1 0", res_dec, res_auth_ok, busy, err_proto);
    end
    do_handshake();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enc_retire got valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_decrypt_pass();
    do_start(4'd5); do_finish(T_DEC);
    do_start(4'd6); do_finish({64'h0, EXP_T});
    checks++;
    if (res_valid !== 1'b1 || res_dec !== 1'b1 || res_auth_ok !== 1'b1 || res_text !== T_DEC || res_tag !== EXP_T) begin
      errors++;
      $display("FAIL dec_pass got valid=%b dec=%b auth=%b text=%h tag=%h", res_valid, res_dec, res_auth_ok, res_text, res_tag);
    end
    do_handshake();
  endtask

  task automatic test_decrypt_fail();
    logic [TEXT_W-1:0] want_text;
`ifdef XOOD_MASK_PT_EN
    want_text = {TEXT_W{1'b0}};
`else
    want_text = T_DEC2;
`endif
    do_start(4'd5); do_finish(T_DEC2);
    do_start(4'd6); do_finish({TEXT_W{1'b0}});
    checks++;
    if (res_valid !== 1'b1 || res_dec !== 1'b1 || res_auth_ok !== 1'b0 || res_tag !== {TAG_W{1'b0}}) begin
      errors++;
      $display("FAIL dec_fail_flags got valid=%b dec=%b auth=%b tag=%h want 1 1 0 0", res_valid, res_dec, res_auth_ok, res_tag);
    end
    checks++;
    if (res_text !== want_text) begin
      errors++;
      $display("FAIL dec_fail_text got %h want %h", res_text, want_text);
    end
    do_handshake();
  endtask

  task automatic test_tag_only();
    do_start(4'd6); do_finish({64'h0, TAG_A5});
    checks++;
    if (res_valid !== 1'b1 || res_text !== {TEXT_W{1'b0}} || res_dec !== 1'b0 || res_auth_ok !== 1'b1 || res_tag !== TAG_A5) begin
      errors++;
      $display("FAIL tag_only got valid=%b text=%h dec=%b auth=%b tag=%h", res_valid, res_text, res_dec, res_auth_ok, res_tag);
    end
    do_handshake();
  endtask

  task automatic test_back_to_back();
    do_start(4'd4); do_finish(T_ENC);
    do_start(4'd6); do_finish({64'h0, TAG_A5});
    // Retire and issue a new op in the same cycle.
    res_ready   = 1'b1;
    core_start  = 1'b1;
    core_opmode = 4'd1;
    @(negedge eph1);
    res_ready   = 1'b0;
    core_start  = 1'b0;
    core_opmode = 4'd0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL b2b_latch got valid=%b busy=%b err=%b want 0 1 0", res_valid, busy, err_proto);
    end
    do_finish(192'h7);
    checks++;
    if (busy !== 1'b0 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got busy=%b err=%b want 0 0", busy, err_proto);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    checks++;
    if (err_proto !== 1'b0) begin
      errors++;
      $display("FAIL bp_err_pre got %b want 0", err_proto);
    end
    do_start(4'd4); do_finish(T_ENC);
    do_start(4'd6); do_finish({64'h0, TAG_A5});
    for (int i = 0; i < 10; i++) begin
      @(negedge eph1);
      if (res_valid !== 1'b1 || res_text !== T_ENC || res_tag !== TAG_A5) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    do_finish(T_DEC);
    checks++;
    if (err_proto !== 1'b1 || res_valid !== 1'b1 || res_text !== T_ENC || res_tag !== TAG_A5 || res_dec !== 1'b0) begin
      errors++;
      $display("FAIL bp_finish got err=%b valid=%b text=%h tag=%h dec=%b", err_proto, res_valid, res_text, res_tag, res_dec);
    end
    do_handshake();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || err_proto !== 1'b1) begin
      errors++;
      $display("FAIL bp_retire got valid=%b busy=%b err=%b want 0 0 1", res_valid, busy, err_proto);
    end
  endtask

  task automatic test_protocol();
    apply_reset();
    checks++;
    if (err_proto !== 1'b0) begin
      errors++;
      $display("FAIL proto_pre got err=%b want 0", err_proto);
    end
    do_finish(T_ENC);
    checks++;
    if (err_proto !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL proto_stray_finish got err=%b valid=%b busy=%b want 1 0 0", err_proto, res_valid, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    do_start(4'd4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_busy got %b want 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({res_valid, res_dec, res_auth_ok, busy, err_proto} !== 5'b0 || res_text !== {TEXT_W{1'b0}}) begin
      errors++;
      $display("FAIL midop_async got flags=%b text=%h want 0", {res_valid, res_dec, res_auth_ok, busy, err_proto}, res_text);
    end
    @(negedge eph1);
    reset = 1'b0;
    repeat (3) @(negedge eph1);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL midop_after got valid=%b busy=%b err=%b want 0 0 0", res_valid, busy, err_proto);
    end
  endtask

  initial begin
    reset         = 1'b1;
    core_start    = 1'b0;
    core_opmode   = 4'd0;
    core_finished = 1'b0;
    core_textout  = {TEXT_W{1'b0}};
    exp_tag       = EXP_T;
    res_ready     = 1'b0;
    @(negedge eph1);
    test_reset();
    test_encrypt();
    test_decrypt_pass();
    test_decrypt_fail();
    test_tag_only();
    test_back_to_back();
    test_backpressure();
    test_protocol();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
